// File: rtl/seriale_pkg.sv
// seriale_pkg: shared encoding and defaults for the serial link
package seriale_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } stato_t;
    localparam int DATA_WIDTH_DEF   = 8;
    localparam int CLKS_PER_BIT_DEF = 4;
endpackage

// File: rtl/generatore_tick.sv
// generatore_tick: bit-period divider, one-cycle tick at the terminal count
module generatore_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic ck,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    logic [TW-1:0] cnt;
    assign tick = enable && !clear && cnt == LAST;
    // count 0..CLKS_PER_BIT-1 and wrap; clear holds it at zero
    always_ff @(posedge ck or negedge reset)
        if (!reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/trasmettitore_seriale.sv
// trasmettitore_seriale: framed LSB-first parallel-to-serial transmitter
module trasmettitore_seriale
    import seriale_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                  ck,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  load,
    output logic                  ready,
    output logic                  tx,
    output logic                  done
);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
    stato_t                state, state_n;
    logic [DATA_WIDTH-1:0] sh, sh_n;
    logic [IW-1:0]         idx, idx_n;
    logic                  tick, tx_n, ready_n, done_n;
    generatore_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .ck    (ck),
        .reset (reset),
        .clear (state == IDLE),
        .enable(state != IDLE),
        .tick  (tick)
    );
    // next state, datapath and output values; outputs are derived from the next state so they leave registers
    always_comb begin
        state_n = state;
        sh_n    = sh;
        idx_n   = idx;
        unique case (state)
            IDLE:  if (load) begin
                state_n = START;
                sh_n    = din;
                idx_n   = '0;
            end
            START: if (tick) state_n = DATA;
            DATA:  if (tick) begin
                sh_n  = sh >> 1;
                idx_n = idx + 1'b1;
                if (idx == LAST_BIT) state_n = STOP;
            end
            STOP:  if (tick) state_n = IDLE;
        endcase
        tx_n    = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
        ready_n = state_n == IDLE;
        done_n  = state == STOP && tick;
    end
    // state and registered outputs; reset returns the line to idle at once
    always_ff @(posedge ck or negedge reset)
        if (!reset) begin
            state <= IDLE;
            sh    <= '0;
            idx   <= '0;
            tx    <= 1'b1;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            idx   <= idx_n;
            tx    <= tx_n;
            ready <= ready_n;
            done  <= done_n;
        end
endmodule

// File: tb/tb_trasmettitore_seriale.sv
// tb_trasmettitore_seriale: randomized + directed check of two transmitter configurations against a frame-timing model
module tb_trasmettitore_seriale;
    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] txv, rdyv, dnv;
    int         nc = 0, nf = 0;

    always #5 ck = ~ck;

    trasmettitore_seriale #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
        .ck(ck), .reset(reset), .din(din), .load(load),
        .ready(rdyv[0]), .tx(txv[0]), .done(dnv[0])
    );
    trasmettitore_seriale #(.DATA_WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
        .ck(ck), .reset(reset), .din(din[0:0]), .load(load),
        .ready(rdyv[1]), .tx(txv[1]), .done(dnv[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // frame model: each instance is either idle or busy since acceptance cycle k with captured word w
    int         dw[2]  = '{8, 1};
    int         cpb[2] = '{4, 1};
    bit         busy[2], dnm[2];
    longint     k[2], cyc = 0;
    logic [7:0] w[2];

    always @(posedge ck or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin busy[i] = 0; dnm[i] = 0; end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                dnm[i] = 0;
                if (busy[i]) begin
                    if (cyc - k[i] == longint'((dw[i] + 2) * cpb[i])) begin busy[i] = 0; dnm[i] = 1; end
                end else if (load) begin
                    busy[i] = 1; k[i] = cyc; w[i] = din;
                end
            end
        end
    end

    // compare every cycle at the falling edge, away from the active edge
    always @(negedge ck) begin
        for (int i = 0; i < 2; i++) begin
            logic etx, erd, edn;
            int   t;
            etx = 1'b1; erd = 1'b1; edn = dnm[i];
            if (busy[i]) begin
                t   = int'(cyc - k[i]);
                erd = 1'b0; edn = 1'b0;
                etx = t < cpb[i] ? 1'b0 : t < (dw[i] + 1) * cpb[i] ? w[i][t / cpb[i] - 1] : 1'b1;
            end
            check($sformatf("model_tx%0d", i), 32'(txv[i]), 32'(etx));
            check($sformatf("model_ready%0d", i), 32'(rdyv[i]), 32'(erd));
            check($sformatf("model_done%0d", i), 32'(dnv[i]), 32'(edn));
        end
    end

    task automatic step();
        @(negedge ck);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rdyv !== 2'b11 && n < 200) begin step(); n++; end
        check("idle_wait", 32'(rdyv), 32'h3);
    endtask

    logic [9:0] a5_seq;
    logic [2:0] c_seq;

    initial begin
        a5_seq = 10'b11_1010_0101 << 0;
        a5_seq = {1'b1, 8'hA5, 1'b0};
        c_seq  = 3'b110;
        #1 reset = 1'b0;
        load = 1'b1; din = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_tx", 32'(txv), 32'h3);
            check("rst_ready", 32'(rdyv), 32'h3);
            check("rst_done", 32'(dnv), 32'h0);
        end
        load = 1'b0; reset = 1'b1;
        repeat (3) step();
        // single frame A5 with a load attempt while busy
        load = 1'b1; din = 8'hA5;
        step();
        load = 1'b0;
        for (int t = 0; t <= 46; t++) begin
            if (t < 40) check("a5_tx", 32'(txv[0]), 32'(a5_seq[t / 4]));
            if (t < 40) check("a5_ready", 32'(rdyv[0]), 32'h0);
            check("a5_done", 32'(dnv[0]), 32'(t == 40));
            if (t > 40) check("a5_quiet", 32'({rdyv[0], txv[0]}), 32'h3);
            if (t < 3) check("w1_tx", 32'(txv[1]), 32'(c_seq[t]));
            if (t <= 4) check("w1_done", 32'(dnv[1]), 32'(t == 3));
            load = (t == 10); din = (t == 10) ? 8'h3C : 8'hA5;
            step();
        end
        load = 1'b0;
        wait_idle();
        // back to back, load held high
        load = 1'b1; din = 8'h00;
        repeat (20) step();
        din = 8'hFF;
        repeat (70) step();
        load = 1'b0;
        wait_idle();
        // mid-frame asynchronous reset
        load = 1'b1; din = 8'hA5;
        step();
        load = 1'b0;
        repeat (17) step();
        @(posedge ck);
        #3 reset = 1'b0;
        #1;
        check("midrst_tx", 32'(txv[0]), 32'h1);
        check("midrst_ready", 32'(rdyv[0]), 32'h1);
        check("midrst_done", 32'(dnv[0]), 32'h0);
        step();
        reset = 1'b1;
        step();
        load = 1'b1; din = 8'h81;
        step();
        load = 1'b0;
        for (int t = 0; t < 40; t++) begin
            check("r81_tx", 32'(txv[0]), 32'({1'b1, 8'h81, 1'b0} >> (t / 4)) & 32'h1);
            step();
        end
        wait_idle();
        // randomized traffic with occasional asynchronous reset pulses
        for (int n = 0; n < 600; n++) begin
            load = ($urandom_range(0, 3) == 0);
            din  = 8'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b0;
                step();
                reset = 1'b1;
            end
            step();
        end
        load = 1'b0;
        wait_idle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
